// File: rtl/data_mem_ctrl_pkg.sv
// Shared state encodings and constants for the MEM-stage data-memory bus bridge.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } dmc_state_e;

  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word bus between the data-memory controller (master) and the external memory (slave).
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output we, output addr, output wdata, input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/data_mem_ctrl.sv
// Bridges MEM-stage load/store requests onto a variable-latency word bus with a watchdog.
// Optional MEM_ALIGN_CHECK_EN: rejects misaligned requests and reports them on align_err_o.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   mem_ce_i,
  input  logic                   mem_wrn_i,
  input  logic [31:0]            mem_addr_i,
  input  logic [31:0]            mem_wrdata_i,
  output logic [31:0]            mem_redata_o,
  output logic                   stall_req_o,
  output logic                   bus_err_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                   align_err_o,
`endif
  data_mem_ctrl_if.master        bus
);

  dmc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             align_q, align_d;
  logic             stall;
  logic             misaligned;
  logic             timeout_hit;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = addr_misaligned(mem_addr_i);
`else
  assign misaligned = Disable;
`endif

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = Disable;
    err_d   = Disable;
    align_d = Disable;
    stall   = Disable;

    unique case (state_q)
      StIdle: begin
        if (mem_ce_i && !flush_i) begin
          stall   = Enable;
          rdata_d = ZeroWord;
          if (misaligned) begin
            // Rejected without touching the bus; the pipeline sees a one-cycle DONE.
            align_d = Enable;
            state_d = StDone;
          end else begin
            we_d    = mem_wrn_i;
            addr_d  = mem_addr_i;
            wdata_d = mem_wrdata_i;
            req_d   = Enable;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        stall = Enable;
        cnt_d = cnt_q + 1'b1;
        // Flush wins over a coincident ack or timeout: nothing is captured or reported.
        if (flush_i) begin
          state_d = StIdle;
        end else if (bus.ack) begin
          rdata_d = we_q ? ZeroWord : bus.rdata;
          state_d = StDone;
        end else if (timeout_hit) begin
          rdata_d = ZeroWord;
          err_d   = Enable;
          state_d = StDone;
        end else begin
          req_d = Enable;
        end
      end

      StDone: begin
        // The request still on mem_ce_i belongs to this access and is not re-issued.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= ZeroWord;
      req_q   <= Disable;
      we_q    <= Disable;
      addr_q  <= ZeroWord;
      wdata_q <= ZeroWord;
      err_q   <= Disable;
      align_q <= Disable;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      align_q <= align_d;
    end
  end

  // Reset forces the combinational stall low so every output reads zero while rst is held.
  assign stall_req_o  = stall & ~rst;
  assign mem_redata_o = (state_q == StDone) ? rdata_q : ZeroWord;
  assign bus_err_o    = err_q;

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err_o = align_q;
`else
  logic unused_align;
  assign unused_align = align_q;
`endif

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Bridges the MEM stage's data-memory request signals to an external synchronous word bus with variable-latency acknowledge. It sits directly downstream of the MEM stage and consumes its chip-enable, write-enable, address and write data. It returns read data to the MEM stage, and raises a stall request to hold the pipeline until the bus access completes. A watchdog aborts accesses that are never acknowledged.

Parameters:
TIMEOUT, 16, max cycles waiting for bus_ack before abort (>=2)
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset
flush  in  1  pipeline flush; aborts any access in flight
mem_ce  in  1  access request from MEM stage; held stable while stall_req=1
mem_wrn  in  1  1=write, 0=read
mem_addr  in  32  byte address (word-aligned)
mem_wrdata  in  32  store data
mem_redata  out  32  load data to MEM stage
stall_req  out  1  pipeline hold request
bus_req  out  1  bus request, held until ack/abort
bus_we  out  1  bus write enable
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_rdata  in  32  bus read data, valid with bus_ack
bus_ack  in  1  single-cycle completion strobe
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset rst, synchronous, active-high. On reset all outputs are 0 and state=IDLE. Reset mid-access drops bus_req on the next edge; no bus_err is raised.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_req = mem_ce & ~flush (combinational). This stalls in the same cycle the request appears.
  - If mem_ce & ~flush: latch mem_wrn/mem_addr/mem_wrdata into bus_we/bus_addr/bus_wdata, set bus_req=1, clear the counter, and go to BUSY.
- BUSY:
  - stall_req=1; bus_req=1; the counter increments each cycle.
  - If bus_ack: bus_req=0; on a read, capture bus_rdata into the rdata register; go to DONE.
  - Else, if the counter reaches TIMEOUT-1: bus_req=0, pulse bus_err for 1 cycle, rdata=0, go to DONE.
  - flush in BUSY takes priority over ack and timeout: bus_req=0, go to IDLE, no capture, no bus_err.
- DONE:
  - stall_req=0 so the pipeline advances with the same instruction; mem_redata = rdata register.
  - Unconditionally go to IDLE. The still-asserted mem_ce is not re-issued.
- Writes return mem_redata=0 in DONE.
- Outside DONE, mem_redata = 0.
- Minimum latency: request cycle plus 1 BUSY cycle (ack on the first BUSY cycle), then DONE. Each access costs ack latency + 2 cycles.
- bus_ack outside BUSY is ignored.
- bus_addr/bus_we/bus_wdata hold their latched values until the next access.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: adds output port align_err (1 bit). In IDLE, a request with mem_addr[1:0]!=0 issues no bus access and goes directly to DONE with rdata=0. align_err pulses high for that DONE cycle and stall_req=1 only in the request cycle.
- Undefined: no align_err port. mem_addr[1:0] is forwarded unchanged on bus_addr.

Decomposition:
- Shared defines file holds the IDLE/BUSY/DONE state encodings (2 bits) and the existing ENABLE/DISABLE/ZeroWord constants.
- No sub-module needed. The watchdog counter stays inline.

Test Plan:
- Read, ack after 3 cycles: mem_ce=1, mem_wrn=0, mem_addr=0x100, bus_rdata=0xDEADBEEF -> bus_addr=0x100 and bus_we=0. stall_req is high for 4 cycles. In DONE, mem_redata=0xDEADBEEF and stall_req=0.
- Write, ack on first BUSY cycle: mem_addr=0x40, mem_wrdata=0x12345678 -> bus_we=1, bus_wdata=0x12345678. Total 3 cycles. mem_redata=0 throughout.
- Timeout, TIMEOUT=16, no ack: bus_req is high for exactly 16 cycles, then bus_err pulses once, then DONE with mem_redata=0, then IDLE.
- Flush on the 2nd BUSY cycle while bus_ack arrives the same cycle -> IDLE, no data capture, no bus_err, stall_req=0 the next cycle.
- Back-to-back reads at 0x0 and 0x4 -> exactly two bus_req episodes, with at least 1 IDLE cycle between them. The held mem_ce in DONE is not re-issued.
- rst asserted mid-BUSY -> the next cycle has bus_req=0, stall_req=0 and all outputs 0. With MEM_ALIGN_CHECK_EN: mem_addr=0x102 -> no bus_req, align_err=1 for one cycle.
